id_dispatch: RTL and testbench

- Parametrised successor of the decode-stage issue path: a one-entry dispatch slot between decoder/register-status read and the ID/EX latch.
- Selects each source operand from PC, immediate, write-back bypass or register file, and allocates a ROB tag at acceptance.
- Holds the instruction under a valid/ready handshake while a reservation station is full.
- While holding, snoops NUM_WB write-back channels so captured operand tags resolve without re-reading.

---
 rtl/id_pkg.sv | 33 +++
 rtl/id_operand_sel.sv | 67 ++++++
 rtl/id_dispatch.sv | 239 +++++++++++++++++++++++
 tb/tb_id_dispatch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared constants and types for the decode-stage dispatch slot:
//               invalid-tag encoding, execution-unit indices, default-width
//               op/tag types and the slot state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

  // Tag value 0 is reserved to mean "operand value is already present".
  localparam int TAG_W_DEF = 4;
  localparam int OP_W_DEF  = 6;

  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [OP_W_DEF-1:0]  op_t;

  localparam tag_t TAG_INVALID = '0;

  // Execution unit indices for the default four-unit configuration. The last
  // unit index never receives work; instructions aimed at it are dropped.
  localparam int EX_ALU      = 0;
  localparam int EX_MUL      = 1;
  localparam int EX_LSU      = 2;
  localparam int EX_ERR_UNIT = 3;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

endpackage : id_pkg
`default_nettype wire

// File: rtl/id_operand_sel.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_sel
// Description : Combinational operand source select with write-back bypass.
//               Priority: direct source (PC/imm) > register with bypass hit >
//               register value/tag > zero. Lowest write-back channel wins when
//               several match. With i_src_en=0 and i_reg_en=1 it also acts as
//               the tag snoop for an operand already held in the slot.
// Ports       : i_src_en/i_src_val   direct source select and value
//               i_reg_en             register source select
//               i_rf_tag/i_rf_val    register-status tag and register value
//               i_wb_valid/tag/data  flattened write-back channels
//               o_val/o_tag          selected operand value and tag
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_sel
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int NUM_WB = 2
) (
  input  logic                    i_src_en,
  input  logic [XLEN-1:0]         i_src_val,
  input  logic                    i_reg_en,
  input  logic [TAG_W-1:0]        i_rf_tag,
  input  logic [XLEN-1:0]         i_rf_val,
  input  logic [NUM_WB-1:0]       i_wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] i_wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]         o_val,
  output logic [TAG_W-1:0]        o_tag
);

  logic            w_hit;
  logic [XLEN-1:0] w_hit_data;

  // Scan from the highest channel down so the lowest matching channel is
  // the last assignment and therefore wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (i_wb_valid[k] && (i_wb_tag[k*TAG_W +: TAG_W] == i_rf_tag)) begin
        w_hit      = 1'b1;
        w_hit_data = i_wb_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_val = '0;
    o_tag = '0;
    if (i_src_en) begin
      o_val = i_src_val;
    end else if (i_reg_en) begin
      if ((i_rf_tag != TAG_W'(TAG_INVALID)) && w_hit) begin
        o_val = w_hit_data;
      end else begin
        o_val = i_rf_val;
        o_tag = i_rf_tag;
      end
    end
  end

endmodule : id_operand_sel
`default_nettype wire

// File: rtl/id_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : id_dispatch
// Description : One-entry dispatch slot between decode/register-status read
//               and the ID/EX latch. Selects operands (PC/imm/bypass/RF),
//               allocates a ROB tag on acceptance, holds the instruction while
//               the target reservation station is full and snoops write-back
//               channels so pending operand tags resolve in place.
// Optional    : define ID_DISPATCH_STATS_EN to add saturating stall counters
//               stat_rob_stall and stat_rs_stall.
// Ports       : clk, rst (async, active high), flush
//               in_*      decoded instruction + valid/ready handshake
//               rf_*      register-status tags and register values
//               rob_*     ROB free-tag interface and allocation pulse
//               wb_*      flattened write-back (CDB) channels
//               rs_full   per-unit reservation station full
//               out_*     held instruction + valid/ready handshake
// Revision    : 1.0 - initial release
// ============================================================================
module id_dispatch
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int NUM_WB = 2,
  parameter int NUM_EX = 4,
  parameter int OP_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [$clog2(NUM_EX)-1:0]  in_ex_unit,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_imm,
  input  logic                       in_pc_en,
  input  logic                       in_imm_en,
  input  logic                       in_rs1_en,
  input  logic                       in_rs2_en,
  input  logic [TAG_W-1:0]           rf_tag1,
  input  logic [TAG_W-1:0]           rf_tag2,
  input  logic [XLEN-1:0]            rf_val1,
  input  logic [XLEN-1:0]            rf_val2,
  input  logic                       rob_full,
  input  logic [TAG_W-1:0]           rob_avail_tag,
  output logic                       rob_alloc,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*XLEN-1:0]     wb_data,
  input  logic [NUM_EX-1:0]          rs_full,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [$clog2(NUM_EX)-1:0]  out_ex_unit,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_imm,
  output logic [TAG_W-1:0]           out_tag1,
  output logic [TAG_W-1:0]           out_tag2,
  output logic [XLEN-1:0]            out_val1,
  output logic [XLEN-1:0]            out_val2,
  output logic [TAG_W-1:0]           out_target
`ifdef ID_DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_rob_stall,
  output logic [31:0]                stat_rs_stall
`endif
);

  localparam int                EXU_W    = $clog2(NUM_EX);
  localparam logic [EXU_W-1:0]  ERR_UNIT = EXU_W'(NUM_EX - 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [OP_W-1:0]   r_op;
  logic [EXU_W-1:0]  r_ex_unit;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_imm;
  logic [TAG_W-1:0]  r_tag1;
  logic [TAG_W-1:0]  r_tag2;
  logic [XLEN-1:0]   r_val1;
  logic [XLEN-1:0]   r_val2;
  logic [TAG_W-1:0]  r_target;

  logic              w_held;
  logic              w_dispatch;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load;

  logic [XLEN-1:0]   w_sel_val1;
  logic [XLEN-1:0]   w_sel_val2;
  logic [TAG_W-1:0]  w_sel_tag1;
  logic [TAG_W-1:0]  w_sel_tag2;

  // --------------------------------------------------------------------------
  // Slot FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held      = (r_state == ST_HELD);
    w_dispatch  = w_held & out_ready & ~rs_full[r_ex_unit];
    w_in_ready  = ~rob_full & (~w_held | w_dispatch) & ~flush;
    w_accept    = in_valid & w_in_ready;
    // Instructions for the error unit are swallowed without a ROB entry.
    w_load      = w_accept & (in_ex_unit != ERR_UNIT);

    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_load) begin
      w_state_nxt = ST_HELD;
    end else if (w_dispatch) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // --------------------------------------------------------------------------
  // Operand select. On a load the selectors see the incoming instruction;
  // otherwise they see the held operand as a register source, which turns
  // them into the write-back snoop for the slot.
  // --------------------------------------------------------------------------
  id_operand_sel #(
    .XLEN   (XLEN),
    .TAG_W  (TAG_W),
    .NUM_WB (NUM_WB)
  ) u_sel1 (
    .i_src_en   (w_load & in_pc_en),
    .i_src_val  (in_pc),
    .i_reg_en   (w_load ? in_rs1_en : 1'b1),
    .i_rf_tag   (w_load ? rf_tag1 : r_tag1),
    .i_rf_val   (w_load ? rf_val1 : r_val1),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .i_wb_data  (wb_data),
    .o_val      (w_sel_val1),
    .o_tag      (w_sel_tag1)
  );

  id_operand_sel #(
    .XLEN   (XLEN),
    .TAG_W  (TAG_W),
    .NUM_WB (NUM_WB)
  ) u_sel2 (
    .i_src_en   (w_load & in_imm_en),
    .i_src_val  (in_imm),
    .i_reg_en   (w_load ? in_rs2_en : 1'b1),
    .i_rf_tag   (w_load ? rf_tag2 : r_tag2),
    .i_rf_val   (w_load ? rf_val2 : r_val2),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .i_wb_data  (wb_data),
    .o_val      (w_sel_val2),
    .o_tag      (w_sel_tag2)
  );

  // --------------------------------------------------------------------------
  // Slot datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_ex_unit <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_val1    <= '0;
      r_val2    <= '0;
      r_target  <= '0;
    end else if (w_load) begin
      r_op      <= in_op;
      r_ex_unit <= in_ex_unit;
      r_pc      <= in_pc;
      r_imm     <= in_imm;
      r_tag1    <= w_sel_tag1;
      r_tag2    <= w_sel_tag2;
      r_val1    <= w_sel_val1;
      r_val2    <= w_sel_val2;
      r_target  <= rob_avail_tag;
    end else if (w_held) begin
      // Snoop result; a resolved tag is replaced by (data, 0), an unresolved
      // or already-zero tag passes through unchanged.
      r_tag1    <= w_sel_tag1;
      r_tag2    <= w_sel_tag2;
      r_val1    <= w_sel_val1;
      r_val2    <= w_sel_val2;
    end
  end

  assign in_ready    = w_in_ready;
  assign rob_alloc   = w_load;
  assign out_valid   = w_held;
  assign out_op      = r_op;
  assign out_ex_unit = r_ex_unit;
  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign out_tag1    = r_tag1;
  assign out_tag2    = r_tag2;
  assign out_val1    = r_val1;
  assign out_val2    = r_val2;
  assign out_target  = r_target;

`ifdef ID_DISPATCH_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating stall counters, cleared only by reset.
  // --------------------------------------------------------------------------
  logic [31:0] r_rob_stall;
  logic [31:0] r_rs_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rob_stall <= '0;
      r_rs_stall  <= '0;
    end else begin
      if (in_valid && rob_full && !(&r_rob_stall)) begin
        r_rob_stall <= r_rob_stall + 32'd1;
      end
      if (w_held && rs_full[r_ex_unit] && !(&r_rs_stall)) begin
        r_rs_stall <= r_rs_stall + 32'd1;
      end
    end
  end

  assign stat_rob_stall = r_rob_stall;
  assign stat_rs_stall  = r_rs_stall;
`endif

endmodule : id_dispatch
`default_nettype wire

// File: tb/tb_id_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_dispatch
// Description : Self-checking bench for id_dispatch. A reference model of the
//               slot occupancy predicts handshake outputs; expected held
//               instructions are queued at acceptance, snooped alongside the
//               DUT and compared while held / popped on dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_dispatch;
  import id_pkg::*;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int NUM_WB = 2;
  localparam int NUM_EX = 4;
  localparam int OP_W   = 6;
  localparam int EXU_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_op;
  logic [EXU_W-1:0]        in_ex_unit;
  logic [XLEN-1:0]         in_pc, in_imm;
  logic                    in_pc_en, in_imm_en, in_rs1_en, in_rs2_en;
  logic [TAG_W-1:0]        rf_tag1, rf_tag2;
  logic [XLEN-1:0]         rf_val1, rf_val2;
  logic                    rob_full;
  logic [TAG_W-1:0]        rob_avail_tag;
  logic                    rob_alloc;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]  wb_data;
  logic [NUM_EX-1:0]       rs_full;
  logic                    out_valid;
  logic                    out_ready;
  logic [OP_W-1:0]         out_op;
  logic [EXU_W-1:0]        out_ex_unit;
  logic [XLEN-1:0]         out_pc, out_imm;
  logic [TAG_W-1:0]        out_tag1, out_tag2;
  logic [XLEN-1:0]         out_val1, out_val2;
  logic [TAG_W-1:0]        out_target;
`ifdef ID_DISPATCH_STATS_EN
  logic [31:0]             stat_rob_stall, stat_rs_stall;
`endif

  always #5 clk = ~clk;

  id_dispatch #(
    .XLEN(XLEN), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .NUM_EX(NUM_EX), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ex_unit(in_ex_unit), .in_pc(in_pc), .in_imm(in_imm),
    .in_pc_en(in_pc_en), .in_imm_en(in_imm_en),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .rf_tag1(rf_tag1), .rf_tag2(rf_tag2), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rob_full(rob_full), .rob_avail_tag(rob_avail_tag), .rob_alloc(rob_alloc),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .rs_full(rs_full),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_ex_unit(out_ex_unit), .out_pc(out_pc), .out_imm(out_imm),
    .out_tag1(out_tag1), .out_tag2(out_tag2),
    .out_val1(out_val1), .out_val2(out_val2), .out_target(out_target)
`ifdef ID_DISPATCH_STATS_EN
    , .stat_rob_stall(stat_rob_stall), .stat_rs_stall(stat_rs_stall)
`endif
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [EXU_W-1:0] unit;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] t1;
    logic [XLEN-1:0]  v1;
    logic [TAG_W-1:0] t2;
    logic [XLEN-1:0]  v2;
    logic [TAG_W-1:0] tgt;
  } exp_t;

  exp_t q[$];
  bit   m_held;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference operand model: direct source, else bypass (channel 0 before
  // channel 1) on a nonzero tag, else register value/tag, else zero.
  function automatic void opnd(input logic src_en, input logic [XLEN-1:0] src,
                               input logic reg_en, input logic [TAG_W-1:0] tg,
                               input logic [XLEN-1:0] v,
                               output logic [XLEN-1:0] ov, output logic [TAG_W-1:0] ot);
    ov = '0;
    ot = '0;
    if (src_en) begin
      ov = src;
    end else if (reg_en) begin
      ov = v;
      ot = tg;
      if (tg != TAG_INVALID) begin
        if (wb_valid[0] && wb_tag[3:0] == tg) begin
          ov = wb_data[31:0];
          ot = '0;
        end else if (wb_valid[1] && wb_tag[7:4] == tg) begin
          ov = wb_data[63:32];
          ot = '0;
        end
      end
    end
  endfunction

  task automatic idle();
    flush = 0; in_valid = 0; in_op = '0; in_ex_unit = '0; in_pc = '0; in_imm = '0;
    in_pc_en = 0; in_imm_en = 0; in_rs1_en = 0; in_rs2_en = 0;
    rf_tag1 = '0; rf_tag2 = '0; rf_val1 = '0; rf_val2 = '0;
    rob_full = 0; rob_avail_tag = 4'd1; wb_valid = '0; wb_tag = '0; wb_data = '0;
    rs_full = '0; out_ready = 0;
  endtask

  // One cycle: inputs were driven after a falling edge; predict, compare,
  // advance the model across the rising edge, return at the next falling edge.
  task automatic step();
    bit disp, rdy, acc, alloc, nxt;
    exp_t e;
    logic [XLEN-1:0] v;
    logic [TAG_W-1:0] t;
    #1;
    disp  = m_held && (q.size() > 0) && out_ready && !rs_full[q[0].unit];
    rdy   = !rob_full && (!m_held || disp) && !flush;
    acc   = in_valid && rdy;
    alloc = acc && (in_ex_unit != EXU_W'(EX_ERR_UNIT));
    check("out_valid", {63'd0, out_valid}, {63'd0, m_held});
    check("in_ready",  {63'd0, in_ready},  {63'd0, rdy});
    check("rob_alloc", {63'd0, rob_alloc}, {63'd0, alloc});
    if (m_held) begin
      if (q.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        check("op",     64'(out_op),      64'(q[0].op));
        check("unit",   64'(out_ex_unit), 64'(q[0].unit));
        check("pc",     64'(out_pc),      64'(q[0].pc));
        check("imm",    64'(out_imm),     64'(q[0].imm));
        check("tag1",   64'(out_tag1),    64'(q[0].t1));
        check("val1",   64'(out_val1),    64'(q[0].v1));
        check("tag2",   64'(out_tag2),    64'(q[0].t2));
        check("val2",   64'(out_val2),    64'(q[0].v2));
        check("target", 64'(out_target),  64'(q[0].tgt));
        if (disp) begin
          void'(q.pop_front());
        end else begin
          opnd(1'b0, '0, 1'b1, q[0].t1, q[0].v1, v, t); q[0].v1 = v; q[0].t1 = t;
          opnd(1'b0, '0, 1'b1, q[0].t2, q[0].v2, v, t); q[0].v2 = v; q[0].t2 = t;
        end
      end
    end
    if (alloc) begin
      e.op = in_op; e.unit = in_ex_unit; e.pc = in_pc; e.imm = in_imm; e.tgt = rob_avail_tag;
      opnd(in_pc_en,  in_pc,  in_rs1_en, rf_tag1, rf_val1, v, t); e.v1 = v; e.t1 = t;
      opnd(in_imm_en, in_imm, in_rs2_en, rf_tag2, rf_val2, v, t); e.v2 = v; e.t2 = t;
      q.push_back(e);
    end
    nxt = flush ? 1'b0 : alloc ? 1'b1 : disp ? 1'b0 : m_held;
    if (flush) q.delete();
    @(posedge clk);
    m_held = nxt;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_held   = 0;
    idle();
    #2;
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_rob_alloc",  {63'd0, rob_alloc}, 64'd0);
    check("rst_out_target", 64'(out_target), 64'd0);
    check("rst_out_val1",   64'(out_val1), 64'd0);
    check("rst_out_op",     64'(out_op), 64'd0);
    @(negedge clk);
    rst = 0;
    step();

    // Basic accept: rs1 from RF (tag 0), imm = -1.
    idle(); in_valid = 1; in_op = 6'h11; in_pc = 32'h100; in_imm = 32'hFFFF_FFFF;
    in_rs1_en = 1; rf_val1 = 32'd5; in_imm_en = 1; rob_avail_tag = 4'd3;
    step();
    check("basic_val1", 64'(out_val1), 64'd5);
    check("basic_val2", 64'(out_val2), 64'hFFFF_FFFF);
    check("basic_target", 64'(out_target), 64'd3);
    idle(); step();
    out_ready = 1; step();

    // Same-cycle bypass from channel 1.
    idle(); in_valid = 1; in_op = 6'h02; in_rs1_en = 1; rf_tag1 = 4'd6; rf_val1 = 32'hDEAD;
    wb_valid = 2'b10; wb_tag = {4'd6, 4'd2}; wb_data = {32'h0000_00AB, 32'h0000_0055};
    rob_avail_tag = 4'd4;
    step();
    check("bypass_val1", 64'(out_val1), 64'hAB);
    check("bypass_tag1", 64'(out_tag1), 64'd0);
    idle(); out_ready = 1; step();

    // Both channels match: channel 0 wins.
    idle(); in_valid = 1; in_rs2_en = 1; rf_tag2 = 4'd5; rf_val2 = 32'h77;
    wb_valid = 2'b11; wb_tag = {4'd5, 4'd5}; wb_data = {32'h22, 32'h33}; rob_avail_tag = 4'd2;
    step();
    check("multi_val2", 64'(out_val2), 64'h33);
    idle(); out_ready = 1; step();

    // Hold on full RS, snoop resolves tag 7 during the hold.
    idle(); in_valid = 1; in_ex_unit = 2'd1; in_rs2_en = 1; rf_tag2 = 4'd7; rf_val2 = 32'h99;
    rob_avail_tag = 4'd5;
    step();
    idle(); out_ready = 1; rs_full = 4'b0010; step();
    wb_valid = 2'b01; wb_tag = {4'd0, 4'd7}; wb_data = {32'h0, 32'h11}; step();
    idle(); out_ready = 1; rs_full = 4'b0010; step();
    check("snoop_tag2", 64'(out_tag2), 64'd0);
    check("snoop_val2", 64'(out_val2), 64'h11);
    rs_full = '0; step();

    // ROB full blocks acceptance.
    idle(); in_valid = 1; rob_full = 1; in_op = 6'h05; rob_avail_tag = 4'd6; step();
    rob_full = 0; step();
    idle(); out_ready = 1; step();

    // Back-to-back dispatch + accept, then flush against a new accept.
    idle(); in_valid = 1; in_op = 6'h0A; in_pc_en = 1; in_pc = 32'h200; rob_avail_tag = 4'd7; step();
    idle(); in_valid = 1; in_op = 6'h0B; in_pc = 32'h204; in_pc_en = 1; rob_avail_tag = 4'd8;
    out_ready = 1; step();
    check("b2b_pc", 64'(out_pc), 64'h204);
    idle(); in_valid = 1; in_op = 6'h0C; flush = 1; rob_avail_tag = 4'd9; step();
    idle(); step();

    // Error unit: consumed without allocation.
    idle(); in_valid = 1; in_ex_unit = EXU_W'(EX_ERR_UNIT); in_op = 6'h3F; step();
    idle(); step();

    // Asynchronous reset while holding.
    idle(); in_valid = 1; in_op = 6'h21; in_imm_en = 1; in_imm = 32'h1234; rob_avail_tag = 4'd10; step();
    idle();
    #2 rst = 1;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_imm", 64'(out_imm), 64'd0);
    q.delete();
    m_held = 0;
    @(negedge clk);
    rst = 0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      idle();
      in_valid      = ($urandom_range(0, 3) != 0);
      in_op         = 6'($urandom);
      in_ex_unit    = 2'($urandom_range(0, 3));
      in_pc         = $urandom;
      in_imm        = $urandom;
      in_pc_en      = ($urandom_range(0, 3) == 0);
      in_imm_en     = ($urandom_range(0, 3) == 0);
      in_rs1_en     = ($urandom_range(0, 3) != 0);
      in_rs2_en     = ($urandom_range(0, 3) != 0);
      rf_tag1       = 4'($urandom_range(0, 7));
      rf_tag2       = 4'($urandom_range(0, 7));
      rf_val1       = $urandom;
      rf_val2       = $urandom;
      rob_full      = ($urandom_range(0, 7) == 0);
      rob_avail_tag = 4'($urandom_range(1, 15));
      wb_valid      = 2'($urandom);
      wb_tag        = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
      wb_data       = {32'($urandom), 32'($urandom)};
      rs_full       = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_id_dispatch
`default_nettype wire
